// File: rtl/scoreboard_hazard_unit_if.sv
//------------------------------------------------------------------------------
// scoreboard_hazard_unit_if
// Issue/hazard bundle between the ID stage and the scoreboard hazard unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface scoreboard_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 3,
    parameter int WB_DEPTH   = 2,
    parameter int CNT_W      = 16
);
    localparam int TAP_W = $clog2(WB_DEPTH + 1);

    logic                          issue_valid;
    logic                          issue_reg_write;
    logic [REG_ADDR_W-1:0]         issue_rd;
    logic [LAT_W-1:0]              issue_lat;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_rs;
    logic [NUM_SRC-1:0]            id_rs_used;
    logic                          flush;
    logic                          stall;
    logic                          stall_raw;
    logic                          stall_struct;
    logic [NUM_SRC*TAP_W-1:0]      fwd_sel;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        output issue_valid, issue_reg_write, issue_rd, issue_lat,
        output id_rs, id_rs_used, flush,
        input  stall, stall_raw, stall_struct, fwd_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_reg_write, issue_rd, issue_lat,
        input  id_rs, id_rs_used, flush,
        output stall, stall_raw, stall_struct, fwd_sel, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/scoreboard_hazard_unit.sv
//------------------------------------------------------------------------------
// scoreboard_hazard_unit
// Per-register result scoreboard: RAW/WAW/writeback-port stalls and bypass selects.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scoreboard_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int MAX_LAT    = 4,
    parameter int LAT_W      = 3,
    parameter int WB_DEPTH   = 2,
    parameter int CNT_W      = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    scoreboard_hazard_unit_if.slave   sb
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    localparam int TAP_W    = $clog2(WB_DEPTH + 1);
    localparam int REM_W    = $clog2(MAX_LAT);

    logic                  r_busy [NUM_REGS];
    logic [REM_W-1:0]      r_rem  [NUM_REGS];
    logic [TAP_W-1:0]      r_tap  [NUM_REGS];
    // Bit j set: some in-flight result first reaches tap 1 in j+1 cycles.
    logic [MAX_LAT-1:0]    r_resv;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [LAT_W-1:0]          w_lat;
    logic [REM_W-1:0]          w_lat_m1;
    logic                      w_valid;
    logic                      w_rd_track;
    logic                      w_waw;
    logic                      w_port;
    logic                      w_raw_any;
    logic [REG_ADDR_W-1:0]     w_addr;
    logic [NUM_SRC*TAP_W-1:0]  w_fwd_sel;
    logic                      w_stall_raw;
    logic                      w_stall_struct;
    logic                      w_stall;
    logic                      w_write;
    logic [MAX_LAT-1:0]        w_resv_new;

    always_comb begin
        w_lat = sb.issue_lat;
        if (sb.issue_lat == '0) begin
            w_lat = LAT_W'(1);
        end else if (sb.issue_lat > LAT_W'(MAX_LAT)) begin
            w_lat = LAT_W'(MAX_LAT);
        end
    end

    assign w_lat_m1   = REM_W'(w_lat - LAT_W'(1));
    assign w_valid    = sb.issue_valid & ~sb.flush;
    // Writes to x0 are discarded, so they are neither tracked nor use the port.
    assign w_rd_track = sb.issue_reg_write & (sb.issue_rd != '0);
    assign w_waw      = w_rd_track & r_busy[sb.issue_rd] & (r_rem[sb.issue_rd] != '0);
    assign w_port     = w_rd_track & r_resv[w_lat_m1];

    always_comb begin
        w_raw_any = 1'b0;
        w_fwd_sel = '0;
        w_addr    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_addr = sb.id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            if ((w_addr != '0) && r_busy[w_addr]) begin
                if (r_rem[w_addr] != '0) begin
                    if (sb.id_rs_used[i]) begin
                        w_raw_any = 1'b1;
                    end
                end else begin
                    w_fwd_sel[i*TAP_W +: TAP_W] = r_tap[w_addr];
                end
            end
        end
    end

    assign w_stall_raw    = w_valid & w_raw_any;
    assign w_stall_struct = w_valid & (w_waw | w_port);
    assign w_stall        = w_stall_raw | w_stall_struct;
    assign w_write        = w_valid & ~w_stall & w_rd_track;

    // An ALU result lands on tap 1 straight away and never needs a reservation.
    assign w_resv_new = (w_write && (w_lat_m1 != '0))
                      ? (MAX_LAT'(1) << (w_lat_m1 - REM_W'(1)))
                      : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_busy[r] <= 1'b0;
                r_rem[r]  <= '0;
                r_tap[r]  <= '0;
            end
            r_resv <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_write && (sb.issue_rd == REG_ADDR_W'(r))) begin
                    r_busy[r] <= 1'b1;
                    r_rem[r]  <= w_lat_m1;
                    r_tap[r]  <= TAP_W'(1);
                end else if (r_busy[r]) begin
                    if (r_rem[r] != '0) begin
                        r_rem[r] <= r_rem[r] - REM_W'(1);
                    end else if (r_tap[r] < TAP_W'(WB_DEPTH)) begin
                        r_tap[r] <= r_tap[r] + TAP_W'(1);
                    end else begin
                        r_busy[r] <= 1'b0;
                    end
                end
            end
            r_resv <= (r_resv >> 1) | w_resv_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign sb.stall        = w_stall;
    assign sb.stall_raw    = w_stall_raw;
    assign sb.stall_struct = w_stall_struct;
    assign sb.fwd_sel      = w_fwd_sel;
    assign sb.stall_cnt    = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
//------------------------------------------------------------------------------
// tb_scoreboard_hazard_unit
// Directed vector table, reset/saturation sequences and a random run against a
// timestamp-based reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_scoreboard_hazard_unit;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int ML = 4;
    localparam int LW = 3;
    localparam int WB = 2;
    localparam int CW = 3;
    localparam int NR = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scoreboard_hazard_unit_if #(
        .REG_ADDR_W(AW), .NUM_SRC(NS), .LAT_W(LW), .WB_DEPTH(WB), .CNT_W(CW)
    ) sb_if ();

    scoreboard_hazard_unit #(
        .REG_ADDR_W(AW), .NUM_SRC(NS), .MAX_LAT(ML), .LAT_W(LW),
        .WB_DEPTH(WB), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    typedef struct {
        logic       iv;
        logic       rw;
        logic [4:0] rd;
        logic [2:0] lat;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       fl;
        logic       st;
        logic       raw;
        logic       str;
        logic [1:0] f0;
        logic [1:0] f1;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [64];
    int   ntbl = 0;
    int   total = 0;
    int   bad = 0;

    // Reference model: each register remembers the absolute cycle its result
    // first appears on tap 1; everything else is derived from the cycle number.
    bit     m_valid [NR];
    longint m_land  [NR];
    longint m_cyc = 0;
    int     m_cnt = 0;
    logic       e_st, e_raw, e_str;
    logic [3:0] e_fwd;

    function automatic vec_t mk(int iv, int rw, int rd, int lat, int rs0, int rs1,
                                int used, int fl, int st, int raw, int str,
                                int f0, int f1, int cnt);
        vec_t v;
        v.iv = iv[0];   v.rw = rw[0];    v.rd = rd[4:0];   v.lat = lat[2:0];
        v.rs0 = rs0[4:0]; v.rs1 = rs1[4:0]; v.used = used[1:0]; v.fl = fl[0];
        v.st = st[0];   v.raw = raw[0];  v.str = str[0];
        v.f0 = f0[1:0]; v.f1 = f1[1:0];  v.cnt = cnt[2:0];
        return v;
    endfunction

    function automatic int norm_lat(logic [2:0] lat);
        if (lat == 3'd0) return 1;
        if (int'(lat) > ML) return ML;
        return int'(lat);
    endfunction

    function automatic bit m_busy(logic [4:0] r);
        return (r != 5'd0) && m_valid[r] && (m_cyc < m_land[r] + WB);
    endfunction

    function automatic bit m_pend(logic [4:0] r);
        return m_busy(r) && (m_cyc < m_land[r]);
    endfunction

    function automatic void model_eval(vec_t v);
        bit         raw, waw, port, valid, track;
        logic [4:0] a;
        int         lat;
        raw   = 1'b0;
        port  = 1'b0;
        e_fwd = '0;
        for (int i = 0; i < NS; i++) begin
            a = (i == 0) ? v.rs0 : v.rs1;
            if (v.used[i] && m_pend(a)) raw = 1'b1;
            if (m_busy(a) && !m_pend(a)) e_fwd[i*2 +: 2] = 2'(m_cyc - m_land[a] + 1);
        end
        lat   = norm_lat(v.lat);
        track = v.rw && (v.rd != 5'd0);
        waw   = track && m_pend(v.rd);
        for (int r = 1; r < NR; r++) begin
            if (track && m_valid[r] && (m_land[r] == m_cyc + lat)) port = 1'b1;
        end
        valid = v.iv && !v.fl;
        e_raw = valid && raw;
        e_str = valid && (waw || port);
        e_st  = e_raw || e_str;
    endfunction

    function automatic void model_clock(vec_t v);
        if (e_st && (m_cnt < (1 << CW) - 1)) m_cnt++;
        if (v.iv && !v.fl && !e_st && v.rw && (v.rd != 5'd0)) begin
            m_valid[v.rd] = 1'b1;
            m_land[v.rd]  = m_cyc + norm_lat(v.lat);
        end
        m_cyc++;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) m_valid[r] = 1'b0;
        m_cnt = 0;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    task automatic drive(vec_t v);
        sb_if.issue_valid     = v.iv;
        sb_if.issue_reg_write = v.rw;
        sb_if.issue_rd        = v.rd;
        sb_if.issue_lat       = v.lat;
        sb_if.id_rs           = {v.rs1, v.rs0};
        sb_if.id_rs_used      = v.used;
        sb_if.flush           = v.fl;
    endtask

    task automatic check_zero(string tag);
        check({tag, "_stall"},  32'(sb_if.stall),        32'd0);
        check({tag, "_raw"},    32'(sb_if.stall_raw),    32'd0);
        check({tag, "_struct"}, 32'(sb_if.stall_struct), 32'd0);
        check({tag, "_fwd"},    32'(sb_if.fwd_sel),      32'd0);
        check({tag, "_cnt"},    32'(sb_if.stall_cnt),    32'd0);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(vec_t v, bit use_tbl);
        drive(v);
        @(negedge clk);
        model_eval(v);
        if (use_tbl) begin
            check("tbl_stall",  32'(sb_if.stall),        32'(v.st));
            check("tbl_raw",    32'(sb_if.stall_raw),    32'(v.raw));
            check("tbl_struct", 32'(sb_if.stall_struct), 32'(v.str));
            check("tbl_fwd0",   32'(sb_if.fwd_sel[1:0]), 32'(v.f0));
            check("tbl_fwd1",   32'(sb_if.fwd_sel[3:2]), 32'(v.f1));
            check("tbl_cnt",    32'(sb_if.stall_cnt),    32'(v.cnt));
        end else begin
            check("mdl_stall",  32'(sb_if.stall),        32'(e_st));
            check("mdl_raw",    32'(sb_if.stall_raw),    32'(e_raw));
            check("mdl_struct", 32'(sb_if.stall_struct), 32'(e_str));
            check("mdl_fwd",    32'(sb_if.fwd_sel),      32'(e_fwd));
            check("mdl_cnt",    32'(sb_if.stall_cnt),    32'(m_cnt));
        end
        @(posedge clk);
        model_clock(v);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t rnd_vec();
        vec_t v;
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.iv   = ($urandom_range(0, 9) < 8);
        v.rw   = ($urandom_range(0, 4) != 0);
        v.rd   = 5'($urandom_range(0, 7));
        v.lat  = 3'($urandom_range(0, 7));
        v.rs0  = 5'($urandom_range(0, 7));
        v.rs1  = 5'($urandom_range(0, 7));
        v.used = 2'($urandom_range(0, 3));
        v.fl   = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        vec_t v;
        //            iv rw rd lat rs0 rs1 u fl | st raw str f0 f1 cnt
        tbl[ntbl++] = mk(1, 1,  5, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[ntbl++] = mk(1, 0,  0, 0,  5,  0, 1, 0,  0, 0, 0, 1, 0, 0);
        tbl[ntbl++] = mk(1, 0,  0, 0,  5,  0, 1, 0,  0, 0, 0, 2, 0, 0);
        tbl[ntbl++] = mk(1, 0,  0, 0,  5,  0, 1, 0,  0, 0, 0, 0, 0, 0);
        tbl[ntbl++] = mk(1, 1,  7, 2,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0,  7, 2, 0,  1, 1, 0, 0, 0, 0);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0,  7, 2, 0,  0, 0, 0, 0, 1, 1);
        tbl[ntbl++] = mk(1, 1,  9, 4,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1);
        tbl[ntbl++] = mk(1, 0,  0, 0,  9,  3, 3, 0,  1, 1, 0, 0, 0, 1);
        tbl[ntbl++] = mk(1, 0,  0, 0,  9,  3, 3, 0,  1, 1, 0, 0, 0, 2);
        tbl[ntbl++] = mk(1, 0,  0, 0,  9,  3, 3, 0,  1, 1, 0, 0, 0, 3);
        tbl[ntbl++] = mk(1, 0,  0, 0,  9,  3, 3, 0,  0, 0, 0, 1, 0, 4);
        tbl[ntbl++] = mk(1, 1,  9, 4,  9,  0, 0, 0,  0, 0, 0, 2, 0, 4);
        tbl[ntbl++] = mk(1, 0,  0, 0,  3,  9, 1, 0,  0, 0, 0, 0, 0, 4);
        tbl[ntbl++] = mk(1, 1,  4, 3,  0,  0, 0, 0,  0, 0, 0, 0, 0, 4);
        tbl[ntbl++] = mk(1, 1,  6, 2,  0,  0, 0, 0,  1, 0, 1, 0, 0, 4);
        tbl[ntbl++] = mk(1, 1,  6, 2,  0,  0, 0, 0,  0, 0, 0, 0, 0, 5);
        tbl[ntbl++] = mk(1, 1,  4, 3,  0,  0, 0, 0,  0, 0, 0, 0, 0, 5);
        tbl[ntbl++] = mk(1, 1,  4, 1,  0,  0, 0, 0,  1, 0, 1, 0, 0, 5);
        tbl[ntbl++] = mk(1, 1,  4, 1,  0,  0, 0, 0,  1, 0, 1, 0, 0, 6);
        tbl[ntbl++] = mk(1, 1,  4, 1,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 1,  8, 3,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 1,  8, 1,  8,  0, 1, 1,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  8,  0, 1, 0,  1, 1, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  8,  0, 1, 0,  0, 0, 0, 1, 0, 7);
        tbl[ntbl++] = mk(1, 1,  0, 4,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0,  0, 3, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0,  0, 3, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 1, 12, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0, 12,  0, 1, 0,  0, 0, 0, 1, 0, 7);
        tbl[ntbl++] = mk(1, 1, 13, 7,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0, 13, 2, 0,  1, 1, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0, 13, 2, 0,  1, 1, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0, 13, 2, 0,  1, 1, 0, 0, 0, 7);
        tbl[ntbl++] = mk(1, 0,  0, 0,  0, 13, 2, 0,  0, 0, 0, 0, 1, 7);
        tbl[ntbl++] = mk(1, 1, 14, 4,  0,  0, 0, 0,  0, 0, 0, 0, 0, 7);
        tbl[ntbl++] = mk(0, 0,  0, 0, 14,  0, 1, 0,  0, 0, 0, 0, 0, 7);

        // Reset state with a would-be hazard sitting in ID.
        model_reset();
        drive(mk(1, 1, 5, 2, 5, 5, 3, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_edge");
        rst_n = 1'b1;

        for (int i = 0; i < ntbl; i++) step(tbl[i], 1'b1);

        // Asynchronous reset in the middle of a RAW stall on x9.
        do_reset();
        step(mk(1, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        v = mk(1, 0, 0, 0, 9, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(v, 1'b0);
        drive(v);
        @(negedge clk);
        check("mid_stall", 32'(sb_if.stall),     32'd1);
        check("mid_cnt",   32'(sb_if.stall_cnt), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(v, 1'b0);

        // Twelve stalled cycles in four multiply rounds saturate the counter.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(mk(1, 1, 10 + k, 4, (k == 0) ? 0 : 9 + k, 0, 1, 0,
                    0, 0, 0, 0, 0, 0), 1'b0);
            repeat (3) step(mk(1, 0, 0, 0, 10 + k, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        end
        check("sat_cnt", 32'(sb_if.stall_cnt), 32'd7);

        for (int n = 0; n < 3000; n++) begin
            if ((n % 60) == 0) do_reset();
            step(rnd_vec(), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
